// File: rtl/ysyx_23060111_exu_mdu.sv
// Multi-cycle RV M-extension unit: iterative shift-add multiply and restoring
// divide. Operates on magnitudes and applies signs once the last step is done.
// Requests and results each use a valid/ready handshake.
module ysyx_23060111_exu_mdu #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  // Multiply: {partial product hi, multiplier/product lo}.
  // Divide:   {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;     // product / quotient is negative
  logic                rneg_q, rneg_d;   // remainder is negative
  logic [XLEN-1:0]     res_q, res_d;
  logic [4:0]          rd_q, rd_d;

  // Request decode
  logic              is_div, s1_signed, s2_signed, sgn1, sgn2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] fast_prod, fast_sprod;
  logic [XLEN-1:0]   fast_res;

  // Operand decode: signedness per funct3, magnitudes and one-cycle results.
  always_comb begin
    is_div    = in_funct3[2];
    s1_signed = (!in_funct3[2] && (in_funct3[1] ^ in_funct3[0])) ||
                (in_funct3[2] && !in_funct3[0]);
    s2_signed = (in_funct3 == 3'b001) || (in_funct3[2] && !in_funct3[0]);
    sgn1      = s1_signed && in_src1[XLEN-1];
    sgn2      = s2_signed && in_src2[XLEN-1];
    mag1      = sgn1 ? -in_src1 : in_src1;
    mag2      = sgn2 ? -in_src2 : in_src2;
    div_zero  = is_div && (in_src2 == '0);
    div_ovf   = is_div && !in_funct3[0] && (in_src1 == INT_MIN) && (in_src2 == ALL_ONE);
    // Divide by zero takes precedence; overflow only matters for a nonzero divisor.
    if (div_zero)
      special_res = in_funct3[1] ? in_src1 : ALL_ONE;
    else
      special_res = in_funct3[1] ? '0 : in_src1;
    fast_prod  = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    fast_sprod = (sgn1 ^ sgn2) ? -fast_prod : fast_prod;
    fast_res   = (in_funct3[1:0] == 2'b00) ? fast_sprod[XLEN-1:0]
                                           : fast_sprod[2*XLEN-1:XLEN];
  end

  // One iteration step for the operation held in op_q
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh, diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] step, prod_f;
  logic [XLEN-1:0]   quo, rem, fin_res;

  // Single shift-add / restoring-subtract step plus final sign fix-up.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = rem_sh - {1'b0, opb_q};
    // Shifted remainder with bit XLEN set already exceeds any divisor.
    rem_ge  = rem_sh[XLEN] || !diff[XLEN];
    if (op_q[2])
      step = rem_ge ? {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                    : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      step = {mul_sum, acc_q[XLEN-1:1]};
    prod_f = neg_q ? -step : step;
    quo    = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem    = rneg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    if (op_q[2])
      fin_res = op_q[1] ? rem : quo;
    else
      fin_res = (op_q[1:0] == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
  end

  assign in_ready   = (state_q == S_IDLE) && !flush;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_result = res_q;
  assign out_rd     = rd_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          op_d   = in_funct3;
          rd_d   = in_rd;
          neg_d  = sgn1 ^ sgn2;
          rneg_d = sgn1;
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            state_d = S_DONE;
          end else if (FAST_MUL && !is_div) begin
            res_d   = fast_res;
            state_d = S_DONE;
          end else begin
            cnt_d   = CW'(XLEN - 1);
            opb_d   = is_div ? mag2 : mag1;
            acc_d   = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          res_d   = fin_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Redirect/trap abandons whatever is in flight, including an unconsumed result.
    if (flush) state_d = S_IDLE;
  end

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060111_exu_mdu.sv
// Bench for the M-extension unit: directed cases, special cases, backpressure,
// flush/reset abort and randomized ops against a plain-arithmetic model.
module tb_ysyx_23060111_exu_mdu;
  localparam int XLEN = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  ysyx_23060111_exu_mdu #(.XLEN(XLEN), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics with 64-bit arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == INT_MIN) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from accept edge (inclusive) to out_valid
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && ((b == 0) || (!f[0] && a == INT_MIN && b == 32'hFFFF_FFFF))) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return INT_MIN;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold, input string tag);
    logic [31:0] exp;
    int lat;
    exp = ref_mdu(f, a, b);
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = f; in_src1 = a; in_src2 = b; in_rd = rd;
    chk($sformatf("%s.in_ready", tag), 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_src1 = $urandom; in_src2 = $urandom; in_rd = 5'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("%s.lat", tag), 64'(lat), 64'(ref_lat(f, a, b)));
    chk($sformatf("%s.result", tag), 64'(out_result), 64'(exp));
    chk($sformatf("%s.rd", tag), 64'(out_rd), 64'(rd));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s.hold_valid", tag), 64'(out_valid), 64'd1);
      chk($sformatf("%s.hold_result", tag), 64'(out_result), 64'(exp));
      chk($sformatf("%s.hold_rd", tag), 64'(out_rd), 64'(rd));
      chk($sformatf("%s.hold_in_ready", tag), 64'(in_ready), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk($sformatf("%s.post_busy", tag), 64'(busy), 64'd0);
    chk($sformatf("%s.post_valid", tag), 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    logic [2:0] f;
    // Reset with a pending request: nothing gets accepted
    rst_n = 1'b0; in_valid = 1'b1; in_funct3 = 3'd4; in_src1 = 32'd9; in_src2 = 32'd3; in_rd = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.out_result", 64'(out_result), 64'd0);
    chk("rst.out_rd", 64'(out_rd), 64'd0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    #1 chk("rst.in_ready", 64'(in_ready), 64'd1);

    // Directed multiply / divide
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, "mul");
    run_op(3'd1, INT_MIN, INT_MIN, 5'd6, 0, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd8, 0, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 0, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 0, "rem");
    run_op(3'd7, 32'd100, 32'd7, 5'd11, 0, "remu");
    run_op(3'd5, 32'hFFFF_FFFF, 32'd3, 5'd12, 0, "divu");

    // Special cases: one-cycle completion
    run_op(3'd5, 32'd5, 32'd0, 5'd13, 0, "sp.divu0");
    run_op(3'd6, 32'd5, 32'd0, 5'd14, 0, "sp.rem0");
    run_op(3'd4, INT_MIN, 32'hFFFF_FFFF, 5'd15, 0, "sp.divovf");
    run_op(3'd6, INT_MIN, 32'hFFFF_FFFF, 5'd16, 0, "sp.removf");

    // Backpressure for 10 cycles, then back-to-back op
    run_op(3'd4, 32'd1000, 32'hFFFF_FFF9, 5'd17, 10, "bp.div");
    run_op(3'd5, 32'd0, 32'd0, 5'd18, 10, "bp.sp");
    run_op(3'd3, 32'd3, 32'd5, 5'd19, 0, "bp.next");

    // Flush blocks acceptance in the same cycle
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_funct3 = 3'd5; in_src1 = 32'd1; in_src2 = 32'd0;
    #1 chk("flush.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    chk("flush.noaccept", 64'(busy), 64'd0);

    // Flush mid-CALC of a divide
    @(negedge clk); in_valid = 1'b1; in_funct3 = 3'd4; in_src1 = 32'd1000; in_src2 = 32'd3; in_rd = 5'd20;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flushcalc.busy", 64'(busy), 64'd0);
    chk("flushcalc.valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("flushcalc.never_valid", 64'(seen), 64'd0);
    run_op(3'd3, 32'd3, 32'd5, 5'd21, 0, "flush.mulhu");

    // Reset mid-CALC
    @(negedge clk); in_valid = 1'b1; in_funct3 = 3'd4; in_src1 = 32'd1000; in_src2 = 32'd3; in_rd = 5'd22;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    chk("rstcalc.busy", 64'(busy), 64'd0);
    chk("rstcalc.valid", 64'(out_valid), 64'd0);
    chk("rstcalc.result", 64'(out_result), 64'd0);
    chk("rstcalc.rd", 64'(out_rd), 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("rstcalc.never_valid", 64'(seen), 64'd0);
    run_op(3'd3, 32'd3, 32'd5, 5'd23, 0, "rst.mulhu");

    // Randomized ops
    for (int k = 0; k < 30; k++) begin
      f = 3'($urandom_range(0, 7));
      run_op(f, pick(), pick(), 5'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d.f%0d", k, f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
